data_cache_wb: RTL

Write-back, direct-mapped data cache between the CPU's byte-wide load/store port and the 32-bit-block data memory. It serves CPU requests from 8 lines × 4 bytes. On a miss it evicts a dirty line to data memory, refills from data memory, and then completes the access. The CPU holds its PC for as long as BUSYWAIT is high.

---
 rtl/data_cache_if.sv | 35 +++
 rtl/data_cache_wb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/data_cache_if.sv
// ---------------------------------------------------------------------------
// data_cache_if
//   Bundles the two buses of the write-back data cache:
//     CPU side    : READ, WRITE, ADDRESS[7:0], WRITEDATA[7:0] -> cache
//                   READDATA[7:0], BUSYWAIT                   <- cache
//     Memory side : MEM_READ, MEM_WRITE, MEM_ADDRESS[5:0],
//                   MEM_WRITEDATA[31:0]                       <- cache
//                   MEM_READDATA[31:0], MEM_BUSYWAIT          -> cache
//   slave  : the cache's view.
//   master : the CPU/data-memory environment's view.
// ---------------------------------------------------------------------------
interface data_cache_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/data_cache_wb.sv
// ---------------------------------------------------------------------------
// data_cache_wb
//   Write-back, direct-mapped data cache: 8 lines x 4 bytes, byte-wide CPU
//   port, 32-bit block port to data memory. Misses evict a dirty line
//   (WRITEBACK), refill the line (FETCH, FILL) and then complete as a hit.
//   Ports:
//     CLK   : system clock, rising edge
//     RESET : asynchronous, active-high
//     bus   : data_cache_if.slave (CPU load/store port + data-memory port)
//   Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = [1:0].
// ---------------------------------------------------------------------------
module data_cache_wb (
    input  logic          CLK,
    input  logic          RESET,
    data_cache_if.slave   bus
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FETCH     = 2'd2;
    localparam logic [1:0] ST_FILL      = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  dirty_q, dirty_d;
    logic [2:0]  tag_q  [8];
    logic [2:0]  tag_d  [8];
    logic [31:0] data_q [8];
    logic [31:0] data_d [8];

    logic [2:0]  addr_tag;
    logic [2:0]  addr_idx;
    logic [4:0]  byte_lsb;
    logic        req;
    logic        wr_req;
    logic        rd_req;
    logic        hit;

    always_comb begin
        addr_tag = bus.ADDRESS[7:5];
        addr_idx = bus.ADDRESS[4:2];
        byte_lsb = {bus.ADDRESS[1:0], 3'b000};
        req      = bus.READ | bus.WRITE;
        // WRITE wins when both strobes are high.
        wr_req   = bus.WRITE;
        rd_req   = bus.READ & ~bus.WRITE;
        hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    end

    // Next-state and line-update logic.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_req && hit) begin
                    data_d[addr_idx][byte_lsb +: 8] = bus.WRITEDATA;
                    dirty_d[addr_idx]               = 1'b1;
                end else if (req && !hit) begin
                    if (valid_q[addr_idx] && dirty_q[addr_idx])
                        state_d = ST_WRITEBACK;
                    else
                        state_d = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                if (!bus.MEM_BUSYWAIT)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!bus.MEM_BUSYWAIT)
                    state_d = ST_FILL;
            end
            default: begin
                // The memory holds the fetched block after completing, so the
                // line is installed here; the pending store lands in IDLE.
                data_d[addr_idx]  = bus.MEM_READDATA;
                tag_d[addr_idx]   = addr_tag;
                valid_d[addr_idx] = 1'b1;
                dirty_d[addr_idx] = 1'b0;
                state_d           = ST_IDLE;
            end
        endcase
    end

    // Control state: asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage: contents are meaningless until valid is set.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // CPU-side outputs are forced quiet while RESET is held.
    always_comb begin
        bus.READDATA = 8'h00;
        bus.BUSYWAIT = 1'b0;
        if (!RESET) begin
            if (state_q == ST_IDLE && rd_req && hit)
                bus.READDATA = data_q[addr_idx][byte_lsb +: 8];
            bus.BUSYWAIT = req && !(state_q == ST_IDLE && hit);
        end
    end

    // Memory-side outputs decode the registered state only.
    always_comb begin
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = 6'h00;
        bus.MEM_WRITEDATA = 32'h0;
        case (state_q)
            ST_WRITEBACK: begin
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
                bus.MEM_WRITEDATA = data_q[addr_idx];
            end
            ST_FETCH: begin
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = bus.ADDRESS[7:2];
            end
            default: ;
        endcase
    end

endmodule
